uart_cfg_ctrl: RTL and testbench

Register-configuration controller that sits directly behind `uart_rx`. It consumes received bytes through `uart_rx`'s valid/ready handshake, parses fixed 4-byte command frames, and validates each frame's checksum and address. Valid frames write a bank of four 8-bit configuration registers that drive the rest of the design. Malformed or stalled frames are dropped and counted.

---
 rtl/uart_cfg_ctrl.sv | 102 ++++++++++
 tb/tb_uart_cfg_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_ctrl.sv
// Parses HEADER/ADDR/DATA/CHK frames arriving from uart_rx and writes a bank of
// four 8-bit configuration registers. Bad or stalled frames are dropped and counted.
module uart_cfg_ctrl #(
  parameter int          CLK_FRE    = 50,
  parameter int          TIMEOUT_US = 1000,
  parameter logic [7:0]  HEADER     = 8'h55,
  parameter logic [31:0] CFG_RST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic        rx_data_ready,
  output logic [31:0] cfg_regs,
  output logic        cfg_wr,
  output logic [1:0]  cfg_wr_addr,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  ok_cnt,
  output logic [7:0]  err_cnt
);
  localparam logic [31:0] TIMEOUT_CYC = 32'(CLK_FRE * TIMEOUT_US);

  typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_CHK, S_EXEC} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_q, data_q, chk_q;
  logic [31:0] tcnt;
  logic        capture, in_frame, timeout, accept;

  // ready is high for exactly one cycle after a capture, which blocks a second
  // capture of the same byte while uart_rx is still dropping valid.
  assign capture  = rx_data_valid && !rx_data_ready && (state != S_EXEC);
  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign timeout  = in_frame && !capture && (tcnt == TIMEOUT_CYC - 32'd1);
  assign accept   = (chk_q == 8'(addr_q + data_q)) && (addr_q[7:2] == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR:  if (capture && rx_data == HEADER) state_nxt = S_ADDR;
      S_ADDR: if (capture) state_nxt = S_DATA; else if (timeout) state_nxt = S_HDR;
      S_DATA: if (capture) state_nxt = S_CHK;  else if (timeout) state_nxt = S_HDR;
      S_CHK:  if (capture) state_nxt = S_EXEC; else if (timeout) state_nxt = S_HDR;
      S_EXEC: state_nxt = S_HDR;
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_ready <= 1'b0;
      cfg_regs      <= CFG_RST;
      cfg_wr        <= 1'b0;
      cfg_wr_addr   <= 2'd0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      ok_cnt        <= 8'd0;
      err_cnt       <= 8'd0;
      addr_q        <= 8'd0;
      data_q        <= 8'd0;
      chk_q         <= 8'd0;
      tcnt          <= 32'd0;
    end else begin
      rx_data_ready <= capture;
      cfg_wr        <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;

      if (capture && state == S_ADDR) addr_q <= rx_data;
      if (capture && state == S_DATA) data_q <= rx_data;
      if (capture && state == S_CHK)  chk_q  <= rx_data;

      // Capture beats timeout on the same edge; counter idles at 0 outside a frame.
      if (capture || !in_frame || timeout) tcnt <= 32'd0;
      else                                 tcnt <= tcnt + 32'd1;

      if (state == S_EXEC) begin
        if (accept) begin
          cfg_regs[{addr_q[1:0], 3'b000} +: 8] <= data_q;
          cfg_wr_addr <= addr_q[1:0];
          cfg_wr      <= 1'b1;
          frame_ok    <= 1'b1;
          ok_cnt      <= ok_cnt + 8'd1;
        end else begin
          frame_err   <= 1'b1;
          err_cnt     <= err_cnt + 8'd1;
        end
      end

      if (timeout) begin
        frame_err <= 1'b1;
        err_cnt   <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Bench for uart_cfg_ctrl: directed frames plus random frames, scored against a
// frame-level model (byte queue, arithmetic checksum, register array).
module tb_uart_cfg_ctrl;
  localparam logic [7:0] HDR = 8'h55;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic        rx_data_ready;
  logic [31:0] cfg_regs;
  logic        cfg_wr;
  logic [1:0]  cfg_wr_addr;
  logic        frame_ok, frame_err;
  logic [7:0]  ok_cnt, err_cnt;

  uart_cfg_ctrl #(.CLK_FRE(1), .TIMEOUT_US(100), .HEADER(HDR), .CFG_RST(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .cfg_regs(cfg_regs), .cfg_wr(cfg_wr),
    .cfg_wr_addr(cfg_wr_addr), .frame_ok(frame_ok), .frame_err(frame_err),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;
  int acc_total = 0;

  logic [7:0] mreg [4];
  logic [7:0] mok, merr;
  logic [1:0] mlast;
  logic [7:0] mbuf [$];

  always @(negedge clk) if (cfg_wr === 1'b1) wr_seen++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mpack();
    return {mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mok = 0; merr = 0; mlast = 0;
    mbuf.delete();
  endtask

  // Called at a negedge; returns at a negedge with valid dropped.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data = b;
    rx_data_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rx_data_ready !== 1'b1 && n < 20);
    check("ready_seen", rx_data_ready, 1);
    @(negedge clk);
    check("ready_one_cycle", rx_data_ready, 0);
    rx_data_valid = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    logic [7:0] a, d, c;
    bit acc;
    send_byte(b);
    if (mbuf.size() == 0 && b != HDR) return;
    mbuf.push_back(b);
    if (mbuf.size() < 4) return;
    a = mbuf[1]; d = mbuf[2]; c = mbuf[3];
    mbuf.delete();
    acc = (int'(c) == (int'(a) + int'(d)) % 256) && (int'(a) < 4);
    if (acc) begin
      mreg[a[1:0]] = d; mlast = a[1:0]; mok = mok + 8'd1; acc_total++;
    end else merr = merr + 8'd1;
    check("frame_ok_pulse",  frame_ok,  acc);
    check("frame_err_pulse", frame_err, !acc);
    check("cfg_wr_pulse",    cfg_wr,    acc);
    check("ok_cnt",          ok_cnt,    mok);
    check("err_cnt",         err_cnt,   merr);
    check("cfg_regs",        cfg_regs,  mpack());
    check("cfg_wr_addr",     cfg_wr_addr, mlast);
    @(negedge clk);
    check("frame_ok_end",  frame_ok,  0);
    check("frame_err_end", frame_err, 0);
    check("cfg_wr_end",    cfg_wr,    0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready",   rx_data_ready, 0);
    check("rst_regs",    cfg_regs, 32'h0);
    check("rst_wr",      cfg_wr, 0);
    check("rst_wr_addr", cfg_wr_addr, 0);
    check("rst_ok",      frame_ok, 0);
    check("rst_err",     frame_err, 0);
    check("rst_ok_cnt",  ok_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
  endtask

  initial begin
    logic [7:0] a, d, c, j;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // good write, bad checksum, bad address
    put(8'h55); put(8'h02); put(8'hA5); put(8'hA7);
    check("good_reg2", cfg_regs[23:16], 8'hA5);
    put(8'h55); put(8'h01); put(8'h10); put(8'h12);
    put(8'h55); put(8'h04); put(8'h10); put(8'h14);
    // junk ahead of header
    put(8'h00); put(8'hFF); put(8'h55); put(8'h00); put(8'h3C); put(8'h3C);
    check("junk_reg0", cfg_regs[7:0], 8'h3C);

    // timeout: frame_err exactly 100 edges after the 01 capture
    put(8'h55); put(8'h01);
    repeat (98) @(negedge clk);
    check("timeout_early", frame_err, 0);
    @(negedge clk);
    check("timeout_pulse", frame_err, 1);
    mbuf.delete();
    merr = merr + 8'd1;
    check("timeout_err_cnt", err_cnt, merr);
    check("timeout_regs", cfg_regs, mpack());
    @(negedge clk);
    check("timeout_pulse_end", frame_err, 0);
    put(8'h55); put(8'h01); put(8'h07); put(8'h08);
    check("after_timeout_reg1", cfg_regs[15:8], 8'h07);

    // header byte used as ordinary data inside a frame
    put(8'h55); put(8'h00); put(8'h55); put(8'h55);

    // random frames with junk, bad checksums and out-of-range addresses
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = 8'($urandom);
        if (j == HDR) j = 8'h00;
        put(j);
      end
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      c = a + d;
      if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
      put(HDR); put(a); put(d); put(c);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // reset mid-frame
    put(8'h55); put(8'h03);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(8'h55); put(8'h03); put(8'h11); put(8'h14);
    check("post_reset_reg3", cfg_regs[31:24], 8'h11);

    check("cfg_wr_total", wr_seen, acc_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
